// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures one byte per done
// rising edge into a first-word-fall-through FIFO with valid/ready read port.
module uart_rx_fifo #(
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_in,
    input  logic [7:0]       rxdata_in,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              done_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem_q [DEPTH];

    logic push_req;
    logic pop;
    logic push;

    // Status decodes come straight from the registered count
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    assign push_req = done_in & ~done_q;
    assign pop      = rd_valid & rd_ready;
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // A dropped byte outranks a same-cycle clear
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // done_q resets high so a done already asserted at reset release is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= rxdata_in;
        end
    end

endmodule
